// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer
//   Sequencer that drives a downstream 8:1 mux (d/sel) so that the mux
//   output becomes a serial bit stream. It accepts one byte through a
//   valid/ready handshake, parks it on d_o, and walks sel_o through all eight
//   channels. Each channel is held for DWELL cycles. It also flags the
//   sampling cycle of each bit, the final bit, and frame completion.
//
// Parameters
//   DWELL      cycles each select value is held (1..256)
//   MSB_FIRST  0: sel 0->7, 1: sel 7->0
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   in_valid_i    upstream byte valid
//   in_data_i     upstream byte
//   in_ready_o    block can accept a byte (IDLE and not in reset)
//   d_o           registered mux data bus
//   sel_o         registered mux select
//   bit_strobe_o  last cycle of a dwell window; mux y is valid
//   last_o        strobe of the 8th bit
//   busy_o        frame in progress (SCAN or DONE)
//   done_o        one-cycle pulse after the 8th bit
module mux_scan_serializer #(
  parameter int unsigned DWELL     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic [7:0] d_o,
  output logic [2:0] sel_o,
  output logic       bit_strobe_o,
  output logic       last_o,
  output logic       busy_o,
  output logic       done_o
);

  // Dwell counter needs at least one bit even when DWELL == 1.
  localparam int unsigned    CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DWELL - 1);
  localparam logic [2:0]     SEL_FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0]     SEL_FINAL = MSB_FIRST ? 3'd0 : 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    sel_q,   sel_d;
  logic [7:0]    data_q,  data_d;

  logic accept;
  logic dwell_end;
  logic final_bit;

  // in_ready is the only output that depends on an input (rst_i), so a
  // byte presented together with reset is never taken.
  assign in_ready_o = (state_q == S_IDLE) & ~rst_i;
  assign accept     = in_valid_i & in_ready_o;

  // Everything below is decoded from registered state only.
  assign dwell_end  = (state_q == S_SCAN) && (cnt_q == CNT_LAST);
  assign final_bit  = (sel_q == SEL_FINAL);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_SCAN;
      S_SCAN:  if (dwell_end && final_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: data bus, select and dwell counter
  // ---------------------------------------------------------------------
  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d = in_data_i;
          sel_d  = SEL_FIRST;
          cnt_d  = '0;
        end
      end
      S_SCAN: begin
        if (dwell_end) begin
          // On the final bit sel parks on its last channel; the frame
          // never wraps the select.
          if (!final_bit) begin
            cnt_d = '0;
            sel_d = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  always_comb begin
    d_o          = data_q;
    sel_o        = sel_q;
    bit_strobe_o = dwell_end;
    last_o       = dwell_end & final_bit;
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer. Three instances cover DWELL=4 LSB-first,
// DWELL=4 MSB-first and DWELL=1. A behavioural 8:1 mux rebuilds y from
// d/sel. Bits expected at the strobes are queued when a byte is handed in
// and popped as the DUT strobes.
module tb_mux_scan_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  // DUT A: DWELL=4, LSB first
  logic       a_iv, a_rdy, a_stb, a_last, a_busy, a_done;
  logic [7:0] a_id, a_d;
  logic [2:0] a_sel;
  // DUT B: DWELL=4, MSB first
  logic       b_iv, b_rdy, b_stb, b_last, b_busy, b_done;
  logic [7:0] b_id, b_d;
  logic [2:0] b_sel;
  // DUT C: DWELL=1, LSB first
  logic       c_iv, c_rdy, c_stb, c_last, c_busy, c_done;
  logic [7:0] c_id, c_d;
  logic [2:0] c_sel;

  logic a_y, b_y, c_y;
  assign a_y = a_d[a_sel];
  assign b_y = b_d[b_sel];
  assign c_y = c_d[c_sel];

  mux_scan_serializer #(.DWELL(4), .MSB_FIRST(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(a_iv), .in_data_i(a_id),
    .in_ready_o(a_rdy), .d_o(a_d), .sel_o(a_sel), .bit_strobe_o(a_stb),
    .last_o(a_last), .busy_o(a_busy), .done_o(a_done));

  mux_scan_serializer #(.DWELL(4), .MSB_FIRST(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(b_iv), .in_data_i(b_id),
    .in_ready_o(b_rdy), .d_o(b_d), .sel_o(b_sel), .bit_strobe_o(b_stb),
    .last_o(b_last), .busy_o(b_busy), .done_o(b_done));

  mux_scan_serializer #(.DWELL(1), .MSB_FIRST(1'b0)) u_c (
    .clk_i(clk), .rst_i(rst), .in_valid_i(c_iv), .in_data_i(c_id),
    .in_ready_o(c_rdy), .d_o(c_d), .sel_o(c_sel), .bit_strobe_o(c_stb),
    .last_o(c_last), .busy_o(c_busy), .done_o(c_done));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    a_iv = 1'b1; a_id = 8'hAA;
    b_iv = 1'b1; b_id = 8'h55;
    c_iv = 1'b1; c_id = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({a_rdy, a_d, a_sel, a_stb, a_last, a_busy, a_done} !== 16'h0) begin
        errors++;
        $display("FAIL reset_a cyc%0d got rdy=%b d=%h sel=%0d stb=%b last=%b busy=%b done=%b, want all 0",
                 i, a_rdy, a_d, a_sel, a_stb, a_last, a_busy, a_done);
      end
      checks++;
      if ({b_rdy, b_d, b_sel, b_busy, c_rdy, c_d, c_sel, c_busy} !== 26'h0) begin
        errors++;
        $display("FAIL reset_bc cyc%0d got b_rdy=%b b_d=%h b_sel=%0d c_rdy=%b c_d=%h c_sel=%0d, want 0",
                 i, b_rdy, b_d, b_sel, c_rdy, c_d, c_sel);
      end
    end
    rst  = 1'b0;
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
    #1;
    checks++;
    if ({a_rdy, b_rdy, c_rdy} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 111", {a_rdy, b_rdy, c_rdy});
    end
    step();
    checks++;
    if ({a_d, b_d, c_d, a_busy, b_busy, c_busy} !== 27'h0) begin
      errors++;
      $display("FAIL reset_no_accept got a_d=%h b_d=%h c_d=%h busy=%b%b%b want 0",
               a_d, b_d, c_d, a_busy, b_busy, c_busy);
    end
  endtask

  task automatic test_lsb_a5();
    logic [7:0] din;
    logic [2:0] e_sel;
    logic [5:0] got, exp;
    bit         eb;
    din = 8'hA5;
    a_id = din; a_iv = 1'b1;
    checks++;
    if (a_rdy !== 1'b1) begin
      errors++; $display("FAIL lsb_ready got %b want 1", a_rdy);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(din[i]);
    step();
    a_iv = 1'b0; a_id = 8'h00;
    for (int c = 1; c <= 34; c++) begin
      e_sel = (c <= 32) ? 3'((c - 1) / 4) : 3'd7;
      exp = {(c <= 32) && (c % 4 == 0), c == 32, c == 33, c <= 33, c >= 34, 1'b1};
      got = {a_stb, a_last, a_done, a_busy, a_rdy, a_d == din};
      checks++;
      if (got !== exp || a_sel !== e_sel) begin
        errors++;
        $display("FAIL lsb_timing c=%0d got sel=%0d stb/last/done/busy/rdy/dok=%b want sel=%0d %b",
                 c, a_sel, got, e_sel, exp);
      end
      if (a_stb === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL lsb_extra_strobe c=%0d got strobe want none", c);
        end else begin
          eb = exp_q.pop_front();
          if (a_y !== eb) begin
            errors++; $display("FAIL lsb_y c=%0d got %b want %b", c, a_y, eb);
          end
        end
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL lsb_missing_bits got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_msb_81();
    logic [7:0] din;
    logic [2:0] e_sel;
    logic [4:0] got, exp;
    bit         eb;
    din = 8'h81;
    b_id = din; b_iv = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(din[i]);
    step();
    b_iv = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      e_sel = (c <= 32) ? 3'(7 - (c - 1) / 4) : 3'd0;
      exp = {(c <= 32) && (c % 4 == 0), c == 32, c == 33, c <= 33, c >= 34};
      got = {b_stb, b_last, b_done, b_busy, b_rdy};
      checks++;
      if (got !== exp || b_sel !== e_sel || b_d !== din) begin
        errors++;
        $display("FAIL msb_timing c=%0d got sel=%0d d=%h flags=%b want sel=%0d d=%h %b",
                 c, b_sel, b_d, got, e_sel, din, exp);
      end
      if (b_stb === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL msb_extra_strobe c=%0d got strobe want none", c);
        end else begin
          eb = exp_q.pop_front();
          if (b_y !== eb) begin
            errors++; $display("FAIL msb_y c=%0d got %b want %b", c, b_y, eb);
          end
        end
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL msb_missing_bits got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] din;
    bit         eb;
    bit         ok;
    din = 8'h3C;
    a_id = din; a_iv = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(din[i]);
    step();
    for (int c = 1; c <= 35; c++) begin
      if (c == 10) a_id = 8'hC3;
      if (c <= 34) begin
        checks++;
        if (a_d !== din || a_rdy !== (c == 34)) begin
          errors++;
          $display("FAIL b2b_hold c=%0d got d=%h rdy=%b want d=%h rdy=%b",
                   c, a_d, a_rdy, din, c == 34);
        end
      end else begin
        checks++;
        if (a_d !== 8'hC3 || a_busy !== 1'b1 || a_sel !== 3'd0) begin
          errors++;
          $display("FAIL b2b_second got d=%h busy=%b sel=%0d want d=c3 busy=1 sel=0",
                   a_d, a_busy, a_sel);
        end
        a_iv = 1'b0;
      end
      if (a_stb === 1'b1 && c <= 32) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_strobe c=%0d got strobe want none", c);
        end else begin
          eb = exp_q.pop_front();
          if (a_y !== eb) begin
            errors++; $display("FAIL b2b_y c=%0d got %b want %b", c, a_y, eb);
          end
        end
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_missing_bits got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (a_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_drain_timeout got rdy=%b want 1 within 60 cycles", a_rdy);
    end
  endtask

  task automatic test_reset_mid();
    bit pulse;
    a_id = 8'h5A; a_iv = 1'b1;
    step();
    a_iv = 1'b0;
    for (int c = 1; c < 9; c++) step();
    checks++;
    if (a_sel !== 3'd2 || a_busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got sel=%0d busy=%b want sel=2 busy=1", a_sel, a_busy);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({a_busy, a_d, a_sel, a_done, a_last, a_stb, a_rdy} !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_state got busy=%b d=%h sel=%0d done=%b last=%b stb=%b rdy=%b want all 0",
               a_busy, a_d, a_sel, a_done, a_last, a_stb, a_rdy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_rdy !== 1'b1) begin
      errors++; $display("FAIL rstmid_ready got %b want 1", a_rdy);
    end
    pulse = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (a_done !== 1'b0 || a_last !== 1'b0 || a_busy !== 1'b0) pulse = 1'b1;
    end
    checks++;
    if (pulse) begin
      errors++; $display("FAIL rstmid_no_done got done/last/busy activity want none");
    end
  endtask

  task automatic test_dwell1();
    logic [7:0] din;
    logic [2:0] e_sel;
    logic [4:0] got, exp;
    bit         eb;
    din = 8'hFF;
    c_id = din; c_iv = 1'b1;
    checks++;
    if (c_rdy !== 1'b1) begin
      errors++; $display("FAIL d1_ready got %b want 1", c_rdy);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(din[i]);
    step();
    c_iv = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      e_sel = (c <= 8) ? 3'(c - 1) : 3'd7;
      exp = {c <= 8, c == 8, c == 9, c <= 9, c >= 10};
      got = {c_stb, c_last, c_done, c_busy, c_rdy};
      checks++;
      if (got !== exp || c_sel !== e_sel) begin
        errors++;
        $display("FAIL d1_timing c=%0d got sel=%0d flags=%b want sel=%0d %b",
                 c, c_sel, got, e_sel, exp);
      end
      if (c_stb === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL d1_extra_strobe c=%0d got strobe want none", c);
        end else begin
          eb = exp_q.pop_front();
          if (c_y !== eb) begin
            errors++; $display("FAIL d1_y c=%0d got %b want %b", c, c_y, eb);
          end
        end
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL d1_missing_bits got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst  = 1'b1;
    a_iv = 1'b0; a_id = '0;
    b_iv = 1'b0; b_id = '0;
    c_iv = 1'b0; c_id = '0;
    test_reset();
    test_lsb_a5();
    test_msb_81();
    test_back_to_back();
    test_reset_mid();
    test_dwell1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_serializer.md
# mux_scan_serializer

Upstream sequencer for the `mux8to1` selector stage. It accepts one byte through a valid/ready handshake and holds it on the mux data bus. It then steps the 3-bit select through all eight channels, holding each channel for a programmable number of cycles, so the mux output becomes a serial bit stream. It also marks the sampling instant of each bit, the final bit, and completion, so a downstream capture stage can sample `y` without its own timing logic.

## Interface
- `DWELL`, default 4: cycles each select value is held; legal range 1..256.
- `MSB_FIRST`, default 0: select order. 0 = 0→7, 1 = 7→0.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream has a byte on `in_data`.
- `in_data`  in  8  byte to serialize.
- `in_ready`  out  1  block can accept a byte; high only in IDLE and not in reset.
- `d`  out  8  registered data bus; drives mux `d`.
- `sel`  out  3  registered select; drives mux `sel`.
- `bit_strobe`  out  1  one-cycle pulse on the last cycle of each dwell window; mux `y` is stable and valid.
- `last`  out  1  high together with the 8th `bit_strobe` only.
- `busy`  out  1  high in SCAN and DONE.
- `done`  out  1  one-cycle pulse after the 8th bit.

## Operation
- States: IDLE, SCAN, DONE. Reset → IDLE.
- **IDLE**
  - `in_ready` = 1.
  - On an edge with `in_valid & in_ready`: `d` ← `in_data`; `sel` ← 0, or 7 if MSB_FIRST; dwell counter ← 0; next state SCAN.
  - With no handshake, `d` and `sel` hold their values.
- **SCAN**
  - Dwell counter counts 0..DWELL-1. Counter width is clog2(DWELL), minimum 1 bit.
  - `bit_strobe` = 1 while counter == DWELL-1.
  - At counter == DWELL-1 and the bit is not the 8th: counter ← 0; `sel` ← sel+1, or sel-1 if MSB_FIRST. No wrap occurs inside a frame.
  - At counter == DWELL-1 on the 8th bit (sel == 7, or 0 if MSB_FIRST): `last` = 1; next state DONE; `sel` holds.
  - `in_valid` and `in_data` are ignored in this state; `d` never changes during SCAN.
- **DONE**
  - `done` = 1 for exactly one cycle; `d` and `sel` hold; next state IDLE.
- `bit_strobe`, `last` and `done` are decoded from registered state and counter only. They have no combinational path from any input.
- `in_ready` = (state == IDLE) & ~rst.

## Timing
- Reset values: `d`=0, `sel`=0, `bit_strobe`=0, `last`=0, `busy`=0, `done`=0, state IDLE. `in_ready` = 0 while `rst` = 1, and 1 on the first cycle after release.
- Handshake at edge k:
  - `d`/`sel` are valid from cycle k+1.
  - Bit n (n=1..8) strobes in cycle k+n·DWELL.
  - `done` is high in cycle k+8·DWELL+1.
  - `in_ready` returns in cycle k+8·DWELL+2.
- Frame occupancy is 8·DWELL+1 busy cycles. Minimum handshake-to-handshake spacing is 8·DWELL+2 cycles.
- DWELL=1: `sel` changes every cycle and `bit_strobe` is high for 8 consecutive cycles.
- `rst` asserted in any state: on the next edge all outputs return to their reset values and state goes to IDLE. The frame is discarded and no `done` is issued.
- `rst` together with `in_valid`: reset wins and the byte is not accepted.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `in_valid`=1.
  - Required: all outputs 0 and `in_ready`=0 during reset.
  - Required: `in_ready`=1 on the first cycle after release; no byte accepted during reset.
- **DWELL=4, LSB first, `in_data`=8'hA5 through the mux:**
  - Required: `sel` runs 0..7, each value held 4 cycles.
  - Required: strobes at k+4, k+8, …, k+32, and mux `y` at the strobes reads 1,0,1,0,0,1,0,1.
  - Required: `last` at k+32, `done` at k+33.
- **MSB_FIRST=1, `in_data`=8'h81:**
  - Required: `sel` runs 7→0, and `y` at the strobes reads 1,0,0,0,0,0,0,1.
- **Back-to-back:** hold `in_valid`=1 with 8'h3C, then switch `in_data` to 8'hC3 mid-frame.
  - Required: `d` stays 8'h3C through the first frame.
  - Required: 8'hC3 is accepted exactly 34 cycles after the first handshake (DWELL=4).
- **Reset mid-frame:** assert `rst` while `sel`=2.
  - Required: next cycle shows IDLE, `d`=0, `sel`=0, and no `done`/`last` pulse.
- **DWELL=1, `in_data`=8'hFF:**
  - Required: `bit_strobe` is high for 8 consecutive cycles and `y`=1 throughout.
  - Required: `done` at k+9.
